// File: rtl/acb_pkg.sv
// Shared constants and types for the acb GF(2^163) operand sequencer.
package acb_pkg;

  localparam int M = 163;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULSQ = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } seq_state_e;

  // ADD and COPY finish in IDLE without involving acb.
  function automatic logic op_is_local(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_COPY);
  endfunction

endpackage

// File: rtl/acb_seq_regfile.sv
// Field-element register file: instruction and host write ports (instruction
// wins on a shared address) and three combinational read ports.
module acb_seq_regfile
  import acb_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_we,
  input  logic [AW-1:0] inst_addr,
  input  logic [M-1:0]  inst_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [M-1:0]  host_data,
  input  logic [AW-1:0] rd_a_addr,
  output logic [M-1:0]  rd_a_data,
  input  logic [AW-1:0] rd_b_addr,
  output logic [M-1:0]  rd_b_data,
  input  logic [AW-1:0] rd_h_addr,
  output logic [M-1:0]  rd_h_data
);

  logic [M-1:0] regs [NUM_REGS];

  // NOTE: this storage is reset on purpose -- registers must read as zero after
  // rst; a plain RAM without reset would leave them undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking writes; the later instruction write overrides the
      // host write to the same address within this edge.
      if (host_we) regs[host_addr] <= host_data;
      if (inst_we) regs[inst_addr] <= inst_data;
    end
  end

  assign rd_a_data = regs[rd_a_addr];
  assign rd_b_data = regs[rd_b_addr];
  assign rd_h_data = regs[rd_h_addr];

endmodule

// File: rtl/acb_sequencer.sv
// Operand sequencer for the acb GF(2^163) multiplier: IDLE/ISSUE/WAIT control,
// local ADD/COPY, host access when idle. Optional WAIT watchdog: ACB_SEQ_TIMEOUT_EN.
module acb_sequencer
  import acb_pkg::*;
#(
  parameter  int NUM_REGS       = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int AW             = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_srca,
  input  logic [AW-1:0] instr_srcb,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [M-1:0]  host_wr_data,
  input  logic [AW-1:0] host_rd_addr,
  output logic [M-1:0]  host_rd_data,
  output logic          busy,
  output logic          op_done,
  output logic          error,
  output logic [M-1:0]  acb_A,
  output logic [M-1:0]  acb_B,
  output logic          acb_enable,
  output logic          acb_configuration,
  input  logic [M-1:0]  acb_C,
  input  logic          acb_done
);

  if (NUM_REGS < 2) begin : g_bad_num_regs
    $error("acb_sequencer: NUM_REGS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("acb_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  seq_state_e    state;
  logic [AW-1:0] dst_q;
  logic [M-1:0]  rd_a, rd_b;
  logic          accept, local_op, timeout_hit;
  logic          inst_we;
  logic [AW-1:0] inst_addr;
  logic [M-1:0]  inst_data;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign local_op    = op_is_local(instr_op);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    inst_we   = 1'b0;
    inst_addr = instr_dst;
    inst_data = rd_a;
    if (state == ST_WAIT) begin
      inst_we   = acb_done;
      inst_addr = dst_q;
      inst_data = acb_C;
    end else if (accept && local_op) begin
      inst_we = 1'b1;
      if (instr_op == OP_ADD) inst_data = rd_a ^ rd_b;
    end
  end

  acb_seq_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .inst_we   (inst_we),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .host_we   (host_wr_en && !busy),
    .host_addr (host_wr_addr),
    .host_data (host_wr_data),
    .rd_a_addr (instr_srca),
    .rd_a_data (rd_a),
    .rd_b_addr (instr_srcb),
    .rd_b_data (rd_b),
    .rd_h_addr (host_rd_addr),
    .rd_h_data (host_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      dst_q             <= '0;
      acb_A             <= '0;
      acb_B             <= '0;
      acb_enable        <= 1'b0;
      acb_configuration <= 1'b1;
      op_done           <= 1'b0;
    end else begin
      op_done    <= 1'b0;
      acb_enable <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (local_op) begin
              op_done <= 1'b1;
            end else begin
              // Operands are captured at acceptance, so dst may alias a source.
              acb_A             <= rd_a;
              acb_B             <= rd_b;
              acb_configuration <= (instr_op == OP_MUL);
              dst_q             <= instr_dst;
              acb_enable        <= 1'b1;
              state             <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (acb_done) begin
            op_done <= 1'b1;
            state   <= ST_IDLE;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACB_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          error_q;

  // Counter is held at zero outside WAIT, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CW'(1) : '0;
      if (timeout_hit) error_q <= 1'b1;
    end
  end

  assign timeout_hit = (state == ST_WAIT) && !acb_done &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign error       = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

endmodule

// File: doc/acb_sequencer.md
Name: acb_sequencer

Overview:
- Operand sequencer that feeds the acb GF(2^163) arithmetic block and consumes its result.
- Holds a small register file of field elements and accepts one instruction at a time over a valid/ready handshake.
- For multiply ops it drives A/B/enable/configuration into acb, waits for done, then writes C back to a destination register.
- XOR-add and copy run locally without acb; the host loads and reads registers directly when idle.

Parameters:
- M, 163, field width in bits.
- NUM_REGS, 8, register file depth; AW = $clog2(NUM_REGS), 3 by default.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with ACB_SEQ_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  instruction accepted when valid&ready
- instr_op  input  2  00 MUL, 01 MULSQ, 10 ADD (XOR), 11 COPY
- instr_dst  input  AW  destination register
- instr_srca  input  AW  source A
- instr_srcb  input  AW  source B (ignored by COPY)
- host_wr_en  input  1  host register write; honoured only when busy=0
- host_wr_addr  input  AW  host write address
- host_wr_data  input  M  host write data
- host_rd_addr  input  AW  host read address
- host_rd_data  output  M  combinational read of regfile[host_rd_addr]
- busy  output  1  high in ISSUE and WAIT
- op_done  output  1  one-cycle pulse the cycle after any regfile writeback by an instruction
- error  output  1  sticky watchdog flag (0 when the feature is compiled out)
- acb_A  output  M  operand A to acb
- acb_B  output  M  operand B to acb
- acb_enable  output  1  start strobe to acb
- acb_configuration  output  1  1 = product, 0 = squared product
- acb_C  input  M  acb result
- acb_done  input  1  acb completion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - FSM = IDLE; all registers = 0; acb_A = acb_B = 0.
  - acb_enable = 0, acb_configuration = 1.
  - op_done = 0, error = 0, busy = 0.
  - Reset mid-operation abandons the op: no writeback and no op_done.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - instr_ready = 1.
  - ADD/COPY accepted at edge E: regfile[dst] <= srca^srcb (ADD) or srca (COPY) at E. op_done = 1 in the cycle after E. FSM stays in IDLE, so back-to-back ADD/COPY issue every cycle.
  - MUL/MULSQ accepted at edge E: acb_A <= reg[srca], acb_B <= reg[srcb], acb_configuration <= (op == MUL), latched dst; next state ISSUE.
- ISSUE: lasts exactly one cycle with acb_enable = 1, instr_ready = 0; then WAIT.
- WAIT:
  - acb_enable = 0; acb_A, acb_B and acb_configuration stay stable.
  - The first cycle with acb_done = 1 writes regfile[dst] <= acb_C at that edge. op_done = 1 in the next cycle and FSM returns to IDLE.
  - acb_done is ignored outside WAIT.
- Hazards: srca/srcb are read at acceptance, so dst may equal a source. Read-after-write across consecutive instructions sees the new value.
- Host write:
  - Applied at the edge when host_wr_en = 1 and busy = 0.
  - If an ADD/COPY writeback targets the same address in the same cycle, the instruction wins and the host write is dropped.
  - host_wr_en while busy is ignored.
- instr_valid while instr_ready = 0 is held by the producer; there is no queue.

Optional Feature:
- Macro: ACB_SEQ_TIMEOUT_EN.
- With it:
  - A cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without acb_done, error <= 1 (sticky until rst), the FSM returns to IDLE with no writeback and no op_done.
- Without it: WAIT waits indefinitely, error is tied to 0, and the counter logic is absent.

Decomposition:
- Shared package acb_pkg:
  - Field width constant M = 163.
  - Opcode constants OP_MUL, OP_MULSQ, OP_ADD, OP_COPY.
  - FSM state encoding.
- One natural sub-module: acb_seq_regfile. It holds NUM_REGS x M registers with two synchronous write ports (instruction, host) where instruction has priority, and three combinational reads (srca, srcb, host).

Test Plan:
- Reset: assert rst 2 cycles mid-WAIT -> next cycle busy=0, instr_ready=1, acb_enable=0, all host reads 0, no op_done.
- ADD: host writes r1=0x3, r2=0x5; ADD r3=r1^r2 -> r3=0x6, op_done 1 cycle later; a back-to-back COPY r4=r3 next cycle gives r4=0x6.
- MUL: acb stub returns the GF product after 5 cycles; MUL r5=r1*r2 with r1=0x3, r2=0x5 -> acb_enable one cycle, acb_configuration=1, r5=0xF, op_done exactly once.
- MULSQ: same operands, stub returns the squared product when configuration=0 -> acb_configuration=0, r6=0x55; instr_ready=0 throughout ISSUE/WAIT.
- Collision: host write to r3 while ADD targets r3 in the same cycle -> r3 holds the ADD result; host_wr_en during WAIT leaves the target unchanged.
- Timeout (ACB_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): stub never asserts done -> error=1 after 16 WAIT cycles, dst unchanged, FSM back to IDLE, error held until rst.
